// File: rtl/datapath_ctrl.sv
// datapath_ctrl: multi-cycle sequencer for the reg_bank / ALU datapath.
//   clock, reset         : rising-edge clock, synchronous active-high reset
//   instr/_valid/_ready  : 32-bit instruction word, valid/ready handshake
//   opr                  : ALU operation select (held between EXECs)
//   seloutA/B            : reg_bank read addresses (held between READs)
//   enrregA/B            : one-cycle loads of the ALU operand registers
//   cnstB, cnst_enB      : sign-extended immediate substituted for outB
//   cnstA                : LOADI write-back immediate
//   regwe/selwreg/endwreg: write-back strobe, data source, address
//   done, halted, retired: retire pulse, halt flag, retired-instruction count
// Instruction word: [31:28] op, [27:24] rd, [23:20] ra, [19:16] rb,
//   [15] use_imm, [14:0] imm15. op F = LOADI, op E = HALT.
module datapath_ctrl #(
  parameter int DATA_W  = 32,
  parameter int RA_W    = 4,
  parameter int OPR_W   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [OPR_W-1:0]  opr,
  output logic [RA_W-1:0]   seloutA,
  output logic [RA_W-1:0]   seloutB,
  output logic              enrregA,
  output logic              enrregB,
  output logic [DATA_W-1:0] cnstB,
  output logic              cnst_enB,
  output logic [DATA_W-1:0] cnstA,
  output logic              regwe,
  output logic              selwreg,
  output logic [RA_W-1:0]   endwreg,
  output logic              done,
  output logic              halted,
  output logic [15:0]       retired
);

  localparam logic [3:0] OP_LOADI = 4'hF;
  localparam logic [3:0] OP_HALT  = 4'hE;
  localparam logic [3:0] LAT_LAST = 4'(ALU_LAT - 1);

  typedef enum logic [2:0] {IDLE, READ, EXEC, WB, HALT} state_t;

  state_t            state, nstate;
  logic [31:0]       ir;
  logic [3:0]        cnt;
  logic [OPR_W-1:0]  opr_q;
  logic [RA_W-1:0]   sela_q, selb_q;
  logic              halt_pulsed;

  logic [3:0]        op;
  logic [RA_W-1:0]   rd, ra, rb;
  logic              use_imm;
  logic [DATA_W-1:0] imm_sx;

  assign op      = ir[31:28];
  assign rd      = RA_W'(ir[27:24]);
  assign ra      = RA_W'(ir[23:20]);
  assign rb      = RA_W'(ir[19:16]);
  assign use_imm = ir[15];
  assign imm_sx  = {{(DATA_W-15){ir[14]}}, ir[14:0]};

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      ir          <= '0;
      cnt         <= '0;
      opr_q       <= '0;
      sela_q      <= '0;
      selb_q      <= '0;
      halt_pulsed <= 1'b0;
      retired     <= '0;
    end else begin
      state <= nstate;
      // instr is only sampled on the handshake cycle
      if (state == IDLE && instr_valid) ir <= instr;
      cnt <= (state == EXEC) ? cnt + 4'd1 : 4'd0;
      if (state == READ) begin
        sela_q <= ra;
        selb_q <= rb;
      end
      if (state == EXEC) opr_q <= OPR_W'(op);
      if (state == HALT) halt_pulsed <= 1'b1;
      if (done) retired <= retired + 16'd1;
    end
  end

  always_comb begin
    nstate      = state;
    instr_ready = 1'b0;
    // read addresses and opcode are live in their own state, held otherwise
    seloutA     = (state == READ) ? ra : sela_q;
    seloutB     = (state == READ) ? rb : selb_q;
    opr         = (state == EXEC) ? OPR_W'(op) : opr_q;
    enrregA     = 1'b0;
    enrregB     = 1'b0;
    cnstB       = '0;
    cnst_enB    = 1'b0;
    cnstA       = '0;
    regwe       = 1'b0;
    selwreg     = 1'b0;
    endwreg     = '0;
    done        = 1'b0;
    halted      = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) nstate = READ;
      end
      READ: begin
        cnst_enB = use_imm;
        cnstB    = imm_sx;
        if (op == OP_LOADI) begin
          nstate = WB;
        end else if (op == OP_HALT) begin
          nstate = HALT;
        end else begin
          enrregA = 1'b1;
          enrregB = 1'b1;
          nstate  = EXEC;
        end
      end
      EXEC: begin
        if (cnt == LAT_LAST) nstate = WB;
      end
      WB: begin
        endwreg = rd;
        selwreg = (op == OP_LOADI);
        cnstA   = (op == OP_LOADI) ? imm_sx : '0;
        regwe   = (rd != '0);         // r0 is read-only but still retires
        done    = 1'b1;
        nstate  = IDLE;
      end
      HALT: begin
        halted = 1'b1;
        done   = ~halt_pulsed;        // retire the HALT itself exactly once
      end
      default: nstate = IDLE;
    endcase
  end

endmodule

// File: tb/tb_datapath_ctrl.sv
// Bench for datapath_ctrl: cycle-exact checks from the main sequence, plus a
// scoreboard of expected write-back fields popped on every done pulse.
module tb_datapath_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  opr;
  logic [3:0]  seloutA, seloutB;
  logic        enrregA, enrregB;
  logic [31:0] cnstB;
  logic        cnst_enB;
  logic [31:0] cnstA;
  logic        regwe, selwreg;
  logic [3:0]  endwreg;
  logic        done, halted;
  logic [15:0] retired;

  datapath_ctrl #(.DATA_W(32), .RA_W(4), .OPR_W(4), .ALU_LAT(1)) dut (
    .clock(clock), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .opr(opr), .seloutA(seloutA), .seloutB(seloutB),
    .enrregA(enrregA), .enrregB(enrregB), .cnstB(cnstB), .cnst_enB(cnst_enB),
    .cnstA(cnstA), .regwe(regwe), .selwreg(selwreg), .endwreg(endwreg),
    .done(done), .halted(halted), .retired(retired)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        regwe;
    logic [3:0]  endwreg;
    logic        selwreg;
    logic [31:0] cnstA;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t exp_for(input logic [31:0] w);
    exp_t e;
    e.regwe = 1'b0; e.endwreg = 4'd0; e.selwreg = 1'b0; e.cnstA = 32'd0;
    if (w[31:28] != 4'hE) begin
      e.endwreg = w[27:24];
      e.regwe   = (w[27:24] != 4'd0);
      if (w[31:28] == 4'hF) begin
        e.selwreg = 1'b1;
        e.cnstA   = {{17{w[14]}}, w[14:0]};
      end
    end
    return e;
  endfunction

  // scoreboard: every retire must match the oldest outstanding instruction
  always @(negedge clock) begin
    if (done) begin
      if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_regwe",   {31'd0, regwe},   {31'd0, e.regwe});
        chk("sb_endwreg", {28'd0, endwreg}, {28'd0, e.endwreg});
        chk("sb_selwreg", {31'd0, selwreg}, {31'd0, e.selwreg});
        chk("sb_cnstA",   cnstA,            e.cnstA);
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!instr_ready && n < 50) begin cyc(); n++; end
    if (!instr_ready) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  // handshake at cycle t; returns positioned at cycle t+1
  task automatic send(input logic [31:0] w);
    wait_ready();
    instr = w;
    instr_valid = 1'b1;
    sb.push_back(exp_for(w));
    cyc();
    instr_valid = 1'b0;
  endtask

  logic [31:0] bb[3];
  int          hc[3];
  int          hs;

  initial begin
    reset = 1'b1; instr = 32'd0; instr_valid = 1'b0;
    cyc(); cyc();
    chk("rst_ready",   {31'd0, instr_ready}, 32'd1);
    chk("rst_regwe",   {31'd0, regwe},       32'd0);
    chk("rst_done",    {31'd0, done},        32'd0);
    chk("rst_retired", {16'd0, retired},     32'd0);
    chk("rst_halted",  {31'd0, halted},      32'd0);
    chk("rst_opr",     {28'd0, opr},         32'd0);
    reset = 1'b0;
    cyc();

    // ALU op: op 3, rd 1, ra 2, rb 3
    send(32'h3123_0000);
    chk("rd_selA",  {28'd0, seloutA},     32'd2);
    chk("rd_selB",  {28'd0, seloutB},     32'd3);
    chk("rd_enA",   {31'd0, enrregA},     32'd1);
    chk("rd_enB",   {31'd0, enrregB},     32'd1);
    chk("rd_ready", {31'd0, instr_ready}, 32'd0);
    cyc();
    chk("ex_opr",   {28'd0, opr},         32'd3);
    chk("ex_enA",   {31'd0, enrregA},     32'd0);
    cyc();
    chk("wb_regwe",   {31'd0, regwe},   32'd1);
    chk("wb_endwreg", {28'd0, endwreg}, 32'd1);
    chk("wb_selwreg", {31'd0, selwreg}, 32'd0);
    chk("wb_done",    {31'd0, done},    32'd1);
    cyc();
    chk("t4_ready",   {31'd0, instr_ready}, 32'd1);
    chk("t4_retired", {16'd0, retired},     32'd1);
    chk("t4_oprhold", {28'd0, opr},         32'd3);
    chk("t4_selhold", {28'd0, seloutA},     32'd2);
    chk("t4_done",    {31'd0, done},        32'd0);

    // LOADI r5 <- sext(0x7FFF)
    send(32'hF500_7FFF);
    chk("li_enA", {31'd0, enrregA}, 32'd0);
    chk("li_enB", {31'd0, enrregB}, 32'd0);
    cyc();
    chk("li_regwe",   {31'd0, regwe},   32'd1);
    chk("li_selwreg", {31'd0, selwreg}, 32'd1);
    chk("li_cnstA",   cnstA,            32'hFFFF_FFFF);
    chk("li_endwreg", {28'd0, endwreg}, 32'd5);
    chk("li_done",    {31'd0, done},    32'd1);
    cyc();
    chk("li_ready",   {31'd0, instr_ready}, 32'd1);
    chk("li_retired", {16'd0, retired},     32'd2);

    // immediate operand, then same with rd = 0
    send(32'h2412_8005);
    chk("im_cnst_en", {31'd0, cnst_enB}, 32'd1);
    chk("im_cnstB",   cnstB,             32'h0000_0005);
    cyc(); cyc(); cyc();
    chk("im_retired", {16'd0, retired},  32'd3);
    send(32'h2012_8005);
    cyc(); cyc();
    chk("r0_regwe", {31'd0, regwe}, 32'd0);
    chk("r0_done",  {31'd0, done},  32'd1);
    cyc();
    chk("r0_retired", {16'd0, retired}, 32'd4);
    send(32'h2412_C000);
    chk("imn_cnstB", cnstB, 32'hFFFF_C000);
    cyc(); cyc(); cyc();

    // reset during EXEC aborts without write-back
    send(32'h3123_0000);
    cyc();
    reset = 1'b1;
    sb.delete();
    cyc();
    reset = 1'b0;
    chk("ab_ready",   {31'd0, instr_ready}, 32'd1);
    chk("ab_retired", {16'd0, retired},     32'd0);
    chk("ab_regwe",   {31'd0, regwe},       32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("ab_regwe_late", {31'd0, regwe}, 32'd0);
    end

    // back-to-back with instr_valid held high
    bb[0] = 32'h1123_0000; bb[1] = 32'h5456_0000; bb[2] = 32'hA789_0000;
    hs = 0;
    instr = bb[0];
    instr_valid = 1'b1;
    for (int c = 0; c < 40 && hs < 3; c++) begin
      if (instr_ready) begin
        hc[hs] = c;
        sb.push_back(exp_for(instr));
        hs++;
      end
      cyc();
      if (hs < 3) instr = bb[hs];
    end
    instr_valid = 1'b0;
    chk("bb_count", hs, 32'd3);
    chk("bb_gap1",  hc[1] - hc[0], 32'd4);
    chk("bb_gap2",  hc[2] - hc[0], 32'd8);
    wait_ready();
    chk("bb_retired", {16'd0, retired}, 32'd3);

    // retired counter wrap
    force dut.retired = 16'hFFFF;
    cyc();
    release dut.retired;
    chk("wr_pre", {16'd0, retired}, 32'h0000_FFFF);
    send(32'hF300_0001);
    cyc(); cyc();
    chk("wr_retired", {16'd0, retired}, 32'd0);

    // HALT is sticky until reset
    send(32'hE000_0000);
    cyc();
    chk("hl_halted", {31'd0, halted},      32'd1);
    chk("hl_done",   {31'd0, done},        32'd1);
    chk("hl_ready",  {31'd0, instr_ready}, 32'd0);
    instr = 32'h3123_0000;
    instr_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("hl_ready_hold",  {31'd0, instr_ready}, 32'd0);
      chk("hl_halted_hold", {31'd0, halted},      32'd1);
      chk("hl_done_once",   {31'd0, done},        32'd0);
    end
    instr_valid = 1'b0;
    chk("hl_retired", {16'd0, retired}, 32'd1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("hl_clr_halted", {31'd0, halted},      32'd0);
    chk("hl_clr_ready",  {31'd0, instr_ready}, 32'd1);
    chk("sb_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
